// File: rtl/orth_dds_pkg.sv
// Shared types and the elaboration-time quarter-wave sine table builder for orth_dds.
// Table values are computed with integer fixed-point arithmetic so they fold to constants in any tool.
package orth_dds_pkg;

  localparam int     FRAC       = 30;
  // pi/2 scaled by 2^FRAC
  localparam longint HALF_PI_FX = 64'd1686629713;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  typedef struct packed {
    logic sin_neg;
    logic cos_neg;
    logic valid;
  } sign_t;

  // round(A * sin(pi/2 * j / 2^(aw-2))), A = 2^(dw-1) - 1, via a Taylor series on Q30 values.
  function automatic int quarter_sin(input int j, input int aw, input int dw);
    longint qn;
    longint amp;
    longint x;
    longint term;
    longint sum;
    qn   = longint'(1) << (aw - 2);
    amp  = (longint'(1) << (dw - 1)) - 1;
    x    = (HALF_PI_FX * longint'(j)) / qn;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x) >>> FRAC;
      term = (term * x) >>> FRAC;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return int'((sum * amp + (longint'(1) << (FRAC - 1))) >>> FRAC);
  endfunction

endpackage

// File: rtl/orth_dds_rom.sv
// Quarter-wave sine table (N/4+1 entries) with two registered read ports sharing one enable.
module orth_dds_rom
  import orth_dds_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-2:0] addr_a,
  input  logic [AW-2:0] addr_b,
  output logic [DW-2:0] data_a,
  output logic [DW-2:0] data_b
);

  localparam int QN = 1 << (AW - 2);

  logic [DW-2:0] tab [QN+1];

  generate
    for (genvar gi = 0; gi <= QN; gi++) begin : g_tab
      localparam int QV = quarter_sin(gi, AW, DW);
      assign tab[gi] = QV[DW-2:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= tab[addr_a];
      data_b <= tab[addr_b];
    end
  end

endmodule

// File: rtl/orth_dds.sv
// Orthogonal DDS: phase accumulator, phase offset, quadrant fold into a quarter-wave ROM,
// and sign restoration, producing sine and cosine with three enabled cycles of latency.
module orth_dds
  import orth_dds_pkg::*;
#(
  parameter int PW = 32,
  parameter int DW = 12,
  parameter int AW = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PW-1:0]        freq,
  input  logic [PW-1:0]        phase,
  output logic signed [DW-1:0] sin,
  output logic signed [DW-1:0] cos
);

  localparam int            LW      = PW - AW;
  localparam logic [AW-2:0] QUARTER = {1'b1, {(AW - 2){1'b0}}};

  logic [PW-1:0] acc_reg;
  logic [AW-1:0] k_reg;
  logic [AW-1:0] k_next;
  logic          v1_reg;
  sign_t         sign_reg;
  sign_t         sign_next;

  quad_e         sin_quad;
  quad_e         cos_quad;
  logic [AW-3:0] r_off;
  logic [AW-2:0] sin_addr;
  logic [AW-2:0] cos_addr;
  logic [DW-2:0] sin_mag;
  logic [DW-2:0] cos_mag;

  // Only the top AW bits of acc+phase are needed; the low half contributes just its carry.
  generate
    if (LW > 0) begin : g_carry
      logic [LW-1:0] lo_sum;
      logic          lo_carry;
      assign lo_sum   = acc_reg[LW-1:0] + phase[LW-1:0];
      assign lo_carry = (lo_sum < acc_reg[LW-1:0]);
      assign k_next   = acc_reg[PW-1 -: AW] + phase[PW-1 -: AW] + AW'(lo_carry);
    end else begin : g_nocarry
      assign k_next = acc_reg + phase;
    end
  endgenerate

  function automatic logic [AW-2:0] fold(input quad_e q, input logic [AW-3:0] r);
    logic [AW-2:0] rr;
    rr = {1'b0, r};
    if (q == QUAD_1 || q == QUAD_3) begin
      return QUARTER - rr;
    end
    return rr;
  endfunction

  // Cosine is sine at k + N/4, i.e. same offset, quadrant advanced by one.
  always_comb begin
    sin_quad  = quad_e'(k_reg[AW-1:AW-2]);
    cos_quad  = quad_e'(k_reg[AW-1:AW-2] + 2'd1);
    r_off     = k_reg[AW-3:0];
    sin_addr  = fold(sin_quad, r_off);
    cos_addr  = fold(cos_quad, r_off);
    sign_next = '0;
    sign_next.sin_neg = (sin_quad == QUAD_2) || (sin_quad == QUAD_3);
    sign_next.cos_neg = (cos_quad == QUAD_2) || (cos_quad == QUAD_3);
    sign_next.valid   = v1_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
      k_reg   <= '0;
      v1_reg  <= 1'b0;
    end else if (en) begin
      acc_reg <= acc_reg + freq;
      k_reg   <= k_next;
      v1_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg <= '0;
    end else if (en) begin
      sign_reg <= sign_next;
    end
  end

  orth_dds_rom #(
    .AW (AW),
    .DW (DW)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .addr_a (sin_addr),
    .addr_b (cos_addr),
    .data_a (sin_mag),
    .data_b (cos_mag)
  );

  // Valid gating keeps the outputs at 0 until the first real sample reaches stage 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      sin <= '0;
      cos <= '0;
    end else if (en) begin
      if (sign_reg.valid) begin
        sin <= sign_reg.sin_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
        cos <= sign_reg.cos_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
      end else begin
        sin <= '0;
        cos <= '0;
      end
    end
  end

endmodule

// File: tb/tb_orth_dds.sv
// Directed self-checking bench for orth_dds: reset, startup latency, phase points,
// positive/negative sweeps, enable hold and mid-run reset.
module tb_orth_dds;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [31:0]         freq;
  logic [31:0]         phase;
  logic signed [11:0]  sin_w;
  logic signed [11:0]  cos_w;

  int vectors     = 0;
  int miscompares = 0;

  int sweep [16] = '{0, 783, 1447, 1891, 2047, 1891, 1447, 783,
                     0, -783, -1447, -1891, -2047, -1891, -1447, -783};

  localparam int A = 2047;

  orth_dds dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .freq  (freq),
    .phase (phase),
    .sin   (sin_w),
    .cos   (cos_w)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] f, input logic [31:0] ph);
    rst   = 1'b1;
    en    = 1'b1;
    freq  = f;
    phase = ph;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    en    = 1'b1;
    freq  = 32'h1000_0000;
    phase = 32'h4000_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (sin_w !== 12'sd0 || cos_w !== 12'sd0) begin
        miscompares++;
        $display("FAIL reset[%0d]: sin=%0d cos=%0d, expected 0/0", i, sin_w, cos_w);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_startup();
    logic signed [11:0] ec;
    do_reset(32'h0, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step();
      ec = (i >= 3) ? 12'sd2047 : 12'sd0;
      vectors++;
      if (sin_w !== 12'sd0 || cos_w !== ec) begin
        miscompares++;
        $display("FAIL startup edge %0d: sin=%0d cos=%0d, expected 0/%0d", i, sin_w, cos_w, ec);
      end
    end
    $display("test_startup done");
  endtask

  task automatic test_phase();
    logic [31:0] ph_tab  [6] = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000,
                                 32'h0008_0000, 32'hFFF8_0000, 32'h3FF8_0000};
    int          sin_tab [6] = '{2047, 0, -2047, 2, -2, 2047};
    int          cos_tab [6] = '{0, -2047, 0, 2047, 2047, 2};
    logic signed [11:0] es;
    logic signed [11:0] ec;
    do_reset(32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      phase = ph_tab[i];
      step();
      step();
      step();
      es = 12'(sin_tab[i]);
      ec = 12'(cos_tab[i]);
      vectors++;
      if (sin_w !== es || cos_w !== ec) begin
        miscompares++;
        $display("FAIL phase %h: sin=%0d cos=%0d, expected %0d/%0d",
                 ph_tab[i], sin_w, cos_w, es, ec);
      end
      $display("phase %h -> sin=%0d cos=%0d", ph_tab[i], sin_w, cos_w);
    end
  endtask

  task automatic test_sweep(input logic [31:0] f, input bit negative);
    logic signed [11:0] es;
    logic signed [11:0] ec;
    int                 pw;
    do_reset(f, 32'h0);
    step();
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      es = 12'(negative ? -sweep[i % 16] : sweep[i % 16]);
      ec = 12'(sweep[(i + 4) % 16]);
      vectors++;
      if (sin_w !== es || cos_w !== ec) begin
        miscompares++;
        $display("FAIL sweep neg=%0d n=%0d: sin=%0d cos=%0d, expected %0d/%0d",
                 negative, i, sin_w, cos_w, es, ec);
      end
      pw = int'(sin_w) * int'(sin_w) + int'(cos_w) * int'(cos_w);
      vectors++;
      if (pw > A * A + 2 * A || pw < A * A - 2 * A) begin
        miscompares++;
        $display("FAIL power n=%0d: sin^2+cos^2=%0d, required %0d +/- %0d", i, pw, A * A, 2 * A);
      end
    end
    $display("test_sweep neg=%0d done", negative);
  endtask

  task automatic test_enable();
    logic signed [11:0] es;
    logic signed [11:0] ec;
    do_reset(32'h1000_0000, 32'h0);
    step();
    step();
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        en = 1'b0;
        for (int h = 0; h < 5; h++) begin
          step();
          vectors++;
          if (sin_w !== 12'(sweep[5]) || cos_w !== 12'(sweep[9])) begin
            miscompares++;
            $display("FAIL enable hold %0d: sin=%0d cos=%0d, expected %0d/%0d",
                     h, sin_w, cos_w, sweep[5], sweep[9]);
          end
        end
        en = 1'b1;
      end
      step();
      es = 12'(sweep[i % 16]);
      ec = 12'(sweep[(i + 4) % 16]);
      vectors++;
      if (sin_w !== es || cos_w !== ec) begin
        miscompares++;
        $display("FAIL enable seq n=%0d: sin=%0d cos=%0d, expected %0d/%0d", i, sin_w, cos_w, es, ec);
      end
    end
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    logic signed [11:0] es;
    logic signed [11:0] ec;
    do_reset(32'h1000_0000, 32'h0);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (sin_w !== 12'sd0 || cos_w !== 12'sd0) begin
      miscompares++;
      $display("FAIL mid reset edge: sin=%0d cos=%0d, expected 0/0", sin_w, cos_w);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      es = (i >= 3) ? 12'(sweep[i - 3]) : 12'sd0;
      ec = (i >= 3) ? 12'(sweep[i + 1]) : 12'sd0;
      vectors++;
      if (sin_w !== es || cos_w !== ec) begin
        miscompares++;
        $display("FAIL mid reset restart edge %0d: sin=%0d cos=%0d, expected %0d/%0d",
                 i, sin_w, cos_w, es, ec);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    freq  = '0;
    phase = '0;
    test_reset();
    test_startup();
    test_phase();
    test_sweep(32'h1000_0000, 1'b0);
    test_sweep(32'hF000_0000, 1'b1);
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/orth_dds.md
Name: orth_dds

Overview:
- Orthogonal direct digital synthesizer: a phase accumulator drives a quarter-wave sine ROM and produces simultaneous signed sine and cosine samples.
- Serves as a swept or fixed test-tone source feeding filter blocks in the DAQ signal chain, and as an NCO for I/Q mixing.
- The frequency control word (FCW) is freq = 2^PW · f_out / f_clk.

Parameters:
- PW, 32, width of the phase accumulator, freq and phase inputs.
- DW, 12, width of the sin/cos outputs (two's complement).
- AW, 13, phase bits used to address one full sine cycle (N = 2^AW points). Requires AW ≥ 3 and AW ≤ PW.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  clock enable; when low, every register holds its value.
- freq  in  PW  signed FCW added to the accumulator every enabled cycle; negative values run backwards.
- phase  in  PW  phase offset added after the accumulator (2^PW = 360°); sampled combinationally every cycle.
- sin  out  DW  signed sine sample.
- cos  out  DW  signed cosine sample.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While rst=1 at a clk edge, the accumulator, all pipeline registers, sin and cos are cleared to 0. rst has priority over en.
- Accumulator:
  - acc <= acc + freq on each enabled cycle.
  - Modulo-2^PW wrap, no saturation.
  - acc = 0 on the first enabled cycle after reset.
- Stage 1 (enabled cycle): p <= acc + phase (mod 2^PW). Index k = p[PW-1 -: AW] (truncation, no dither). Quadrant q = k[AW-1:AW-2], offset r = k[AW-3:0].
- Stage 2 (enabled cycle):
  - Sine lookup: Q[r] for q=0,2; Q[N/4−r] for q=1,3.
  - Cosine uses index k + N/4 (mod N) with the same fold rule.
  - Sign flags are registered alongside: sine negative for q=2,3; cosine negative for q=1,2.
- Stage 3 (enabled cycle): sin/cos <= negated-or-not ROM values. Results are exactly ±Q, so there is no overflow.
- ROM:
  - Q has N/4+1 entries, j = 0..N/4.
  - Q[j] = round(A·sin(π/2 · j/(N/4))), with A = 2^(DW−1) − 1 (2047 for DW=12).
  - Contents are computed at elaboration by a constant function.
  - Two read ports (sin and cos); reads are registered.
- Result: sin = round(A·sin(2πk/N)) and cos = round(A·cos(2πk/N)), with exact symmetry. Outputs are never −2^(DW−1).
- Latency:
  - The phase input reaches the outputs 3 enabled cycles after it is applied.
  - An accumulator value reaches the outputs 3 enabled cycles after it is registered.
  - After reset release with en=1, the first valid sample (acc=0) appears on the 3rd clock edge. Earlier outputs are 0.
- Boundaries:
  - k = N/4, N/2, 3N/4 give exact ±A / 0 values. q=1 with r=0 uses Q[N/4].
  - freq and phase may change on any cycle with no glitch beyond the pipeline.
  - en low freezes the outputs and the pipeline contents. The pipeline resumes without sample loss when en returns high.
  - Reset mid-operation clears everything on that edge.

Decomposition:
- Package orth_dds_pkg holds the constant function that builds the quarter-wave table, parameterised by AW and DW.
- One sub-module, orth_dds_rom: quarter-wave table with two registered read ports and an enable.
- Accumulator, phase fold and sign logic live in orth_dds.

Test Plan:
- freq=0, phase=0, en=1 after reset -> from the 3rd edge onward sin=0, cos=2047 constantly. Outputs are 0 before that edge.
- freq=0, phase=2^30 -> sin=2047, cos=0. Phase=2^31 -> sin=0, cos=−2047. Phase=3·2^30 -> sin=−2047, cos=0.
- freq=2^28 (f_clk/16), phase=0:
  - sin sequence is 0, 783, 1447, 1891, 2047, 1891, 1447, 783, 0, −783, … with period 16.
  - cos leads sin by 4 samples.
  - sin²+cos² stays within ±2 LSB·A of A² at every sample.
- freq=−2^28 -> sin sequence is 0, −783, −1447, … (time-reversed); cos is identical to the positive-frequency case.
- Toggle en low for 5 cycles mid-sweep -> sin/cos and the accumulator hold. On re-enable the sequence continues from the held point with no skipped sample.
- Assert rst for 1 cycle during freq=2^28 operation -> outputs are 0 on the next edge, then the sequence restarts at 0/2047 after 3 enabled edges.
